l1_dm_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 cache.
- Acts as the responder on the CPU's word-wide cache port: read/write/wmask/address/wdata in, resp/rdata out.
- Acts as the initiator on a 256-bit line-wide physical-memory port.
- One instance serves the instruction port and one serves the data port of the pipelined core.

---
 rtl/l1_dm_cache.sv | 147 ++++++++++++++
 tb/tb_l1_dm_cache.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dm_cache.sv
// Direct-mapped write-back/write-allocate L1: hit responds on the cycle after IDLE, a miss adds a fill, and a dirty victim adds a writeback first.
// No backpressure on the CPU side: the requester holds its request until resp; pmem strobes are held until pmem_resp.
module l1_dm_cache #(
   parameter int S_INDEX  = 3,
   parameter int S_OFFSET = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         read,
   input  logic         write,
   input  logic [3:0]   wmask,
   input  logic [31:0]  address,
   input  logic [31:0]  wdata,
   output logic         resp,
   output logic [31:0]  rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [31:0]  pmem_address,
   output logic [255:0] pmem_wdata,
   input  logic         pmem_resp,
   input  logic [255:0] pmem_rdata
);
   localparam int LINES = 2**S_INDEX;
   localparam int S_TAG = 32 - S_INDEX - S_OFFSET;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

   state_t             state_q;
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;
   logic [S_TAG-1:0]   tag_q  [LINES];
   logic [255:0]       data_q [LINES];
   logic               resp_q;
   logic               pmem_read_q;
   logic               pmem_write_q;
   logic [31:0]        rdata_q;
   logic [31:0]        pmem_address_q;

   logic [2:0]         word;
   logic [7:0]         bit_ofs;
   logic [S_INDEX-1:0] idx;
   logic [S_TAG-1:0]   tag;
   logic               req;
   logic               hit;
   logic [31:0]        cur_word;
   logic [31:0]        fill_word;
   logic [31:0]        wr_word;
   logic               fill_we;
   logic               wr_we;
   logic               unused_addr;

   assign word        = address[4:2];
   assign bit_ofs     = {word, 5'b0};
   assign idx         = address[S_OFFSET +: S_INDEX];
   assign tag         = address[31 -: S_TAG];
   assign unused_addr = ^address[1:0];

   assign req       = read | write;
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign cur_word  = data_q[idx][bit_ofs +: 32];
   assign fill_word = pmem_rdata[bit_ofs +: 32];
   assign fill_we   = (state_q == FILL) && pmem_resp;
   assign wr_we     = (state_q == RESPOND) && write && (wmask != 4'b0);

   always_comb begin
      wr_word = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (wmask[b]) wr_word[8*b +: 8] = wdata[8*b +: 8];
      end
   end

   // Line storage carries no reset; valid_q alone decides whether contents mean anything.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_q[idx] <= pmem_rdata;
         tag_q[idx]  <= tag;
      end else if (wr_we) begin
         data_q[idx][bit_ofs +: 32] <= wr_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         valid_q        <= '0;
         dirty_q        <= '0;
         resp_q         <= 1'b0;
         rdata_q        <= '0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  if (hit) begin
                     state_q <= RESPOND;
                     resp_q  <= 1'b1;
                     rdata_q <= cur_word;
                  end else if (valid_q[idx] && dirty_q[idx]) begin
                     state_q        <= WRITEBACK;
                     pmem_write_q   <= 1'b1;
                     pmem_address_q <= {tag_q[idx], idx, {S_OFFSET{1'b0}}};
                  end else begin
                     state_q        <= FILL;
                     pmem_read_q    <= 1'b1;
                     pmem_address_q <= {tag, idx, {S_OFFSET{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               if (pmem_resp) begin
                  dirty_q[idx]   <= 1'b0;
                  pmem_write_q   <= 1'b0;
                  pmem_read_q    <= 1'b1;
                  pmem_address_q <= {tag, idx, {S_OFFSET{1'b0}}};
                  state_q        <= FILL;
               end
            end
            FILL: begin
               if (pmem_resp) begin
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  pmem_read_q  <= 1'b0;
                  resp_q       <= 1'b1;
                  rdata_q      <= fill_word;
                  state_q      <= RESPOND;
               end
            end
            RESPOND: begin
               resp_q  <= 1'b0;
               rdata_q <= '0;
               if (wr_we) dirty_q[idx] <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp         = resp_q;
   assign rdata        = rdata_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = data_q[idx];
endmodule

// File: tb/tb_l1_dm_cache.sv
// Directed bench for l1_dm_cache: expected CPU responses and memory transactions are queued
// at issue time and popped by independent monitors when the DUT presents them.
module tb_l1_dm_cache;
   logic         clk;
   logic         reset;
   logic         read;
   logic         write;
   logic [3:0]   wmask;
   logic [31:0]  address;
   logic [31:0]  wdata;
   logic         resp;
   logic [31:0]  rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic         pmem_resp;
   logic [255:0] pmem_rdata;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd0;
   } pm_t;

   logic [31:0]  exp_rdata_q[$];
   pm_t          exp_pmem_q[$];
   logic [255:0] mem [logic [31:0]];
   int           mem_lat;
   int           n_checks;
   int           n_fail;
   logic         prev_resp;

   l1_dm_cache dut (
      .clk(clk), .reset(reset), .read(read), .write(write), .wmask(wmask),
      .address(address), .wdata(wdata), .resp(resp), .rdata(rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_pm(input logic wr, input logic [31:0] addr, input logic [31:0] wd0);
      pm_t e;
      e.wr   = wr;
      e.addr = addr;
      e.wd0  = wd0;
      exp_pmem_q.push_back(e);
   endtask

   // Called at posedge+1; holds the request until resp, releases it just after the edge ending RESPOND.
   task automatic req(input string name, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] m, input logic [31:0] exp_rd,
                      input int exp_lat);
      int lat;
      exp_rdata_q.push_back(exp_rd);
      read = rd; write = wr; address = addr; wdata = wd; wmask = m;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp && lat < 200);
      if (!resp) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: no resp after %0d cycles", name, lat);
      end else begin
         chk({name, "_latency"}, lat, exp_lat);
      end
      @(posedge clk);
      #1;
      read = 1'b0; write = 1'b0;
   endtask

   // CPU-side monitor: every resp pops one expected rdata; rdata must return to 0 after it.
   always @(negedge clk) begin
      if (reset) begin
         prev_resp = 1'b0;
      end else begin
         if (resp) begin
            if (exp_rdata_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: rdata 0x%08h with nothing expected", rdata);
            end else begin
               chk("rdata", rdata, exp_rdata_q.pop_front());
            end
         end else if (prev_resp) begin
            chk("rdata_after_resp", rdata, 32'h0);
         end
         if (pmem_read || pmem_write) chk("pmem_strobe_exclusive", {31'b0, pmem_read & pmem_write}, 32'h0);
         prev_resp = resp;
      end
   end

   // Memory model and pmem monitor; a pending transaction is dropped if reset is seen.
   initial begin
      pm_t          e;
      logic [31:0]  a;
      logic         w;
      logic [255:0] wl;
      logic         aborted;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      @(negedge clk);
      forever begin
         if (!reset && (pmem_read || pmem_write)) begin
            if (exp_pmem_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pmem: rd=%0b wr=%0b addr 0x%08h", pmem_read, pmem_write, pmem_address);
            end else begin
               e = exp_pmem_q.pop_front();
               chk("pmem_is_write", {31'b0, pmem_write}, {31'b0, e.wr});
               chk("pmem_address", pmem_address, e.addr);
               if (e.wr) chk("pmem_wdata_word0", pmem_wdata[31:0], e.wd0);
            end
            a = pmem_address; w = pmem_write; wl = pmem_wdata;
            aborted = 1'b0;
            for (int i = 1; i < mem_lat; i++) begin
               @(negedge clk);
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
            end
            if (!aborted) begin
               if (w) mem[a] = wl;
               else   pmem_rdata = mem.exists(a) ? mem[a] : '0;
               pmem_resp = 1'b1;
               @(negedge clk);
               pmem_resp = 1'b0;
            end
         end else begin
            @(negedge clk);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] line;
      n_checks = 0; n_fail = 0; mem_lat = 3; prev_resp = 1'b0;
      read = 0; write = 0; wmask = 0; address = 0; wdata = 0;
      for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'hA000_0000 + i;
      line[31:0] = 32'hDEADBEEF; line[63:32] = 32'h1234_5678;
      mem[32'h40] = line;
      for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h1400_0000 + i;
      mem[32'h140] = line;
      for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h0100_0000 + i;
      mem[32'h100] = line;
      for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h0000_AA00 + i;
      mem[32'h0] = line;

      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_resp", {31'b0, resp}, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_pmem_read", {31'b0, pmem_read}, 32'h0);
      chk("reset_pmem_write", {31'b0, pmem_write}, 32'h0);
      chk("reset_pmem_address", pmem_address, 32'h0);
      #2 reset = 1'b0;
      @(posedge clk); #1;

      exp_pm(1'b0, 32'h40, 32'h0);
      req("miss_read_40", 1, 0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 5);
      req("hit_read_44", 1, 0, 32'h44, 32'h0, 4'h0, 32'h1234_5678, 2);
      chk("hit_no_pmem_pending", exp_pmem_q.size(), 32'h0);
      req("write_40", 0, 1, 32'h40, 32'h1122_3344, 4'b0011, 32'hDEADBEEF, 2);
      chk("dirty_after_write", {31'b0, dut.dirty_q[2]}, 32'h1);
      req("read_merged_40", 1, 0, 32'h40, 32'h0, 4'h0, 32'hDEAD3344, 2);

      exp_pm(1'b1, 32'h40, 32'hDEAD3344);
      exp_pm(1'b0, 32'h140, 32'h0);
      req("dirty_miss_140", 1, 0, 32'h140, 32'h0, 4'h0, 32'h1400_0000, 8);
      exp_pm(1'b0, 32'h40, 32'h0);
      req("refill_44", 1, 0, 32'h44, 32'h0, 4'h0, 32'h1234_5678, 5);

      exp_pm(1'b0, 32'h80, 32'h0);
      mem_lat = 20;
      read = 1'b1; write = 1'b0; address = 32'h80;
      repeat (3) @(negedge clk);
      chk("fill_pending", {31'b0, pmem_read}, 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("rst_fill_pmem_read", {31'b0, pmem_read}, 32'h0);
      chk("rst_fill_resp", {31'b0, resp}, 32'h0);
      chk("rst_fill_pmem_address", pmem_address, 32'h0);
      read = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      mem_lat = 3;
      @(posedge clk); #1;
      exp_pm(1'b0, 32'h40, 32'h0);
      req("post_reset_miss_44", 1, 0, 32'h44, 32'h0, 4'h0, 32'h1234_5678, 5);

      req("rdwr_as_write_44", 1, 1, 32'h44, 32'hCAFEF00D, 4'b1111, 32'h1234_5678, 2);
      req("read_back_44", 1, 0, 32'h44, 32'h0, 4'h0, 32'hCAFEF00D, 2);

      exp_pm(1'b0, 32'h100, 32'h0);
      req("mask0_write_104", 0, 1, 32'h104, 32'hFFFF_FFFF, 4'b0000, 32'h0100_0001, 5);
      chk("mask0_not_dirty", {31'b0, dut.dirty_q[0]}, 32'h0);
      req("mask0_unchanged_104", 1, 0, 32'h104, 32'h0, 4'h0, 32'h0100_0001, 2);
      exp_pm(1'b0, 32'h0, 32'h0);
      req("wrap_conflict_000", 1, 0, 32'h0, 32'h0, 4'h0, 32'h0000_AA00, 5);
      req("stream_hit_004", 1, 0, 32'h4, 32'h0, 4'h0, 32'h0000_AA01, 2);

      repeat (5) @(negedge clk);
      chk("resp_queue_drained", exp_rdata_q.size(), 32'h0);
      chk("pmem_queue_drained", exp_pmem_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
